// File: rtl/single_fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the sqrt stream wrapper:
// operand classes, special encodings and the operand classifier.
package single_fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    DENORM = 3'd1,
    INF    = 3'd2,
    NAN    = 3'd3,
    NEG    = 3'd4,
    NORMAL = 3'd5
  } fp_class_t;

  // Payload keeps the NaN fraction below the quiet bit so it can be re-emitted.
  typedef struct packed {
    logic                  valid;
    fp_class_t             cls;
    logic                  sign;
    logic [FRAC_W-2:0]     payload;
  } cls_pipe_t;

  // Denormals take priority over the sign test so -denorm flushes to -0.
  function automatic fp_class_t fp_classify(input logic [31:0] a);
    logic [EXP_W-1:0]  exp_s;
    logic [FRAC_W-1:0] frac_s;
    fp_class_t         cls_s;
    exp_s  = a[30:23];
    frac_s = a[22:0];
    if (exp_s == 8'h00) begin
      cls_s = (frac_s == 23'd0) ? ZERO : DENORM;
    end else if (exp_s == 8'hFF && frac_s != 23'd0) begin
      cls_s = NAN;
    end else if (a[31]) begin
      cls_s = NEG;
    end else if (exp_s == 8'hFF) begin
      cls_s = INF;
    end else begin
      cls_s = NORMAL;
    end
    return cls_s;
  endfunction

endpackage

// File: rtl/sqrt_result_fifo.sv
// Result FIFO with a registered output stage; an empty FIFO forwards a write
// straight into the output register so data appears on the next cycle.
module sqrt_result_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic mem_empty_s, load_s, bypass_s, mem_we_s, mem_re_s;

  always_comb begin
    mem_empty_s = (mem_cnt_q == '0);
    load_s      = (!out_valid_q || rd_en) && (!mem_empty_s || wr_en);
    bypass_s    = load_s && mem_empty_s;
    mem_we_s    = wr_en && !bypass_s;
    mem_re_s    = load_s && !mem_empty_s;

    wr_ptr_d = mem_we_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = mem_re_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    case ({mem_we_s, mem_re_s})
      2'b10:   mem_cnt_d = mem_cnt_q + CNT_W'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - CNT_W'(1);
      default: mem_cnt_d = mem_cnt_q;
    endcase

    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = bypass_s ? wr_data : mem_q[rd_ptr_q];
    end else begin
      out_valid_d = rd_en ? 1'b0 : out_valid_q;
      out_data_d  = out_data_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage needs no reset: only entries below mem_cnt_q are ever read.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_valid = out_valid_q;
  assign rd_data  = out_data_q;
  assign full     = (mem_cnt_q == CNT_W'(DEPTH));
  assign empty    = !out_valid_q && mem_empty_s;

endmodule

// File: rtl/single_sqrt_stream.sv
// Valid/ready wrapper around the non-stalling single-precision sqrt core.
// Optional SQRT_STREAM_STATS_EN adds saturating pop / invalid-pop counters.
module single_sqrt_stream
  import single_fp_pkg::*;
#(
  parameter int LATENCY = 15,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        sq_in_valid,
  output logic [31:0] sq_a,
  input  logic        sq_out_valid,
  input  logic [31:0] sq_c,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_invalid
`ifdef SQRT_STREAM_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_invalid
`endif
);

  logic             accept_s, pop_s;
  logic             ready_en_q, ready_en_d;
  logic [CNT_W-1:0] count_q, count_d;
  cls_pipe_t        pipe_q [LATENCY];
  cls_pipe_t        pipe_d [LATENCY];
  cls_pipe_t        tail_s;
  logic [31:0]      patch_data_s;
  logic             patch_inv_s;
  logic             fifo_full_s, fifo_empty_s;

  // ready_en_q holds s_ready low while rstn is asserted.
  assign s_ready     = ready_en_q && (count_q < CNT_W'(DEPTH));
  assign accept_s    = s_valid && s_ready;
  assign sq_in_valid = accept_s;
  assign sq_a        = s_data;
  assign pop_s       = m_valid && m_ready;
  assign tail_s      = pipe_q[LATENCY-1];

  always_comb begin
    ready_en_d = 1'b1;
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    pipe_d[0] = '{valid:   accept_s,
                  cls:     fp_classify(s_data),
                  sign:    s_data[31],
                  payload: s_data[FRAC_W-2:0]};
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_en_q <= 1'b0;
      count_q    <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      ready_en_q <= ready_en_d;
      count_q    <= count_d;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // -INF is classed NEG, so the INF arm only ever sees +INF.
  always_comb begin
    patch_data_s = sq_c;
    patch_inv_s  = 1'b0;
    case (tail_s.cls)
      ZERO, DENORM: patch_data_s = {tail_s.sign, 31'd0};
      INF:          patch_data_s = FP_POS_INF;
      NEG: begin
        patch_data_s = FP_QNAN;
        patch_inv_s  = 1'b1;
      end
      NAN:          patch_data_s = {tail_s.sign, 8'hFF, 1'b1, tail_s.payload};
      default:      patch_data_s = sq_c;
    endcase
  end

  sqrt_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (sq_out_valid),
    .wr_data  ({patch_inv_s, patch_data_s}),
    .rd_en    (pop_s),
    .rd_valid (m_valid),
    .rd_data  ({m_invalid, m_data}),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

`ifdef SQRT_STREAM_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_inv_q, stat_inv_d;

  always_comb begin
    stat_ops_d = stat_ops_q;
    stat_inv_d = stat_inv_q;
    if (pop_s && stat_ops_q != 16'hFFFF) begin
      stat_ops_d = stat_ops_q + 16'd1;
    end else begin
      stat_ops_d = stat_ops_q;
    end
    if (pop_s && m_invalid && stat_inv_q != 16'hFFFF) begin
      stat_inv_d = stat_inv_q + 16'd1;
    end else begin
      stat_inv_d = stat_inv_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_ops_q <= 16'd0;
      stat_inv_q <= 16'd0;
    end else begin
      stat_ops_q <= stat_ops_d;
      stat_inv_q <= stat_inv_d;
    end
  end

  assign stat_ops     = stat_ops_q;
  assign stat_invalid = stat_inv_q;
`endif

  tail_valid_a: assert property (@(posedge clk) disable iff (!rstn)
    sq_out_valid == tail_s.valid)
    else $error("sq_out_valid disagrees with class pipeline tail");

  fifo_overflow_a: assert property (@(posedge clk) disable iff (!rstn)
    !(sq_out_valid && fifo_full_s))
    else $error("result fifo written while full");

  fifo_underflow_a: assert property (@(posedge clk) disable iff (!rstn)
    !(pop_s && fifo_empty_s))
    else $error("result fifo popped while empty");

endmodule

// File: tb/tb_single_sqrt_stream.sv
// Bench for single_sqrt_stream: behavioural sqrt core model plus a queue
// scoreboard of expected {invalid, data} results.
module tb_single_sqrt_stream;

  localparam int LAT   = 15;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = 32'd0;
  logic        sq_in_valid;
  logic [31:0] sq_a;
  logic        sq_out_valid;
  logic [31:0] sq_c;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_invalid;

  int n_chk  = 0;
  int n_fail = 0;
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  single_sqrt_stream #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .sq_in_valid  (sq_in_valid),
    .sq_a         (sq_a),
    .sq_out_valid (sq_out_valid),
    .sq_c         (sq_c),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_invalid    (m_invalid)
  );

  function automatic logic [23:0] isqrt48(input logic [47:0] rad);
    logic [23:0] res;
    logic [23:0] t;
    logic [63:0] sq;
    res = 24'd0;
    for (int b = 23; b >= 0; b--) begin
      t  = res | (24'd1 << b);
      sq = 64'(t) * 64'(t);
      if (sq <= 64'(rad)) res = t;
    end
    return res;
  endfunction

  // Truncating sqrt of a positive normal single.
  function automatic logic [31:0] core_sqrt(input logic [31:0] a);
    int          e;
    logic [23:0] m;
    logic [47:0] rad;
    logic [23:0] r;
    logic [7:0]  re;
    m = {1'b1, a[22:0]};
    e = int'(a[30:23]) - 127;
    if (e % 2 != 0) begin
      rad = {m, 24'd0};
      e   = e - 1;
    end else begin
      rad = {1'b0, m, 23'd0};
    end
    r  = isqrt48(rad);
    re = 8'(e / 2 + 127);
    return {1'b0, re, r[22:0]};
  endfunction

  // The core only gives meaningful results for positive normals.
  function automatic logic [31:0] core_fn(input logic [31:0] a);
    if (!a[31] && a[30:23] != 8'h00 && a[30:23] != 8'hFF) return core_sqrt(a);
    return 32'hDEADBEEF;
  endfunction

  function automatic logic [32:0] ref_out(input logic [31:0] a);
    logic [7:0]  ex;
    logic [22:0] fr;
    ex = a[30:23];
    fr = a[22:0];
    if (ex == 8'h00) return {1'b0, a[31], 31'd0};
    if (ex == 8'hFF && fr != 23'd0) return {1'b0, a | 32'h00400000};
    if (a[31]) return {1'b1, 32'h7FC00000};
    if (ex == 8'hFF) return {1'b0, 32'h7F800000};
    return {1'b0, core_sqrt(a)};
  endfunction

  function automatic logic [31:0] rand_norm();
    return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  // Core model: fixed-latency pipeline reset by the shared rstn.
  logic [LAT-1:0] core_v;
  logic [31:0]    core_d [LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) core_v <= '0;
    else       core_v <= {core_v[LAT-2:0], sq_in_valid};
  end

  always_ff @(posedge clk) begin
    core_d[0] <= core_fn(sq_a);
    for (int i = 1; i < LAT; i++) core_d[i] <= core_d[i-1];
  end

  assign sq_out_valid = core_v[LAT-1];
  assign sq_c         = core_d[LAT-1];

  // One cycle from a falling edge to the next; expected value queued on accept.
  task automatic cyc(input logic v, input logic [31:0] d, input logic [32:0] e,
                     input logic r, output logic acc, output logic pop,
                     output logic [32:0] got, output logic rdy, output int qsz);
    s_valid = v;
    s_data  = d;
    m_ready = r;
    #1;
    rdy = s_ready;
    qsz = exp_q.size();
    acc = s_valid & s_ready;
    pop = m_valid & m_ready;
    got = {m_invalid, m_data};
    if (acc) exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_chk += 4;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b required 0", s_ready); end
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b required 0", m_valid); end
    if (m_data !== 32'd0) begin n_fail++; $display("FAIL rst_m_data: got %h required 0", m_data); end
    if (m_invalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_invalid: got %b required 0", m_invalid); end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_chk += 2;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_s_ready: got %b required 1", s_ready); end
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_m_valid: got %b required 0", m_valid); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] ops  [2] = '{32'h40800000, 32'h41100000};
    logic [32:0] exps [2] = '{33'h040000000, 33'h040400000};
    logic acc, pop, rdy;
    logic [32:0] got, e;
    int qsz, lat;
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, ops[k], exps[k], 1'b1, acc, pop, got, rdy, qsz);
      n_chk++;
      if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %b required 1", acc); end
      lat = -1;
      for (int c = 1; c < 40 && lat < 0; c++) begin
        cyc(1'b0, 32'd0, 33'd0, 1'b1, acc, pop, got, rdy, qsz);
        if (pop) begin
          lat = c;
          e = exp_q.pop_front();
          n_chk += 2;
          if (got !== e) begin n_fail++; $display("FAIL basic_data: got %h required %h", got, e); end
          if (c != LAT + 1) begin n_fail++; $display("FAIL basic_latency: got %0d required %0d", c, LAT + 1); end
        end
      end
      if (lat < 0) begin n_chk++; n_fail++; $display("FAIL basic_timeout: got no result required one"); exp_q.delete(); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] ops  [5] = '{32'hC0800000, 32'h7F800000, 32'h80000000, 32'h00000001, 32'h7F800001};
    logic [32:0] exps [5] = '{33'h17FC00000, 33'h07F800000, 33'h080000000, 33'h000000000, 33'h07FC00001};
    logic acc, pop, rdy;
    logic [32:0] got, e;
    int qsz, seen;
    seen = 0;
    for (int k = 0; k < 5; k++) cyc(1'b1, ops[k], exps[k], 1'b1, acc, pop, got, rdy, qsz);
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      cyc(1'b0, 32'd0, 33'd0, 1'b1, acc, pop, got, rdy, qsz);
      if (pop) begin
        e = exp_q.pop_front();
        seen++;
        n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL special_data: got %h required %h", got, e); end
      end
    end
    n_chk++;
    if (seen != 5) begin n_fail++; $display("FAIL special_count: got %0d required 5", seen); exp_q.delete(); end
  endtask

  task automatic test_backpressure();
    logic acc, pop, rdy, popped;
    logic [32:0] got, e;
    logic [31:0] d;
    int qsz, n_acc, seen;
    n_acc = 0;
    seen = 0;
    popped = 1'b0;
    for (int c = 0; c < 30; c++) begin
      d = rand_norm();
      cyc(1'b1, d, ref_out(d), 1'b0, acc, pop, got, rdy, qsz);
      if (acc) n_acc++;
    end
    s_valid = 1'b0;
    #1;
    n_chk += 2;
    if (n_acc != DEPTH) begin n_fail++; $display("FAIL bp_accepts: got %0d required %0d", n_acc, DEPTH); end
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready_low: got %b required 0", s_ready); end
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      cyc(1'b0, 32'd0, 33'd0, 1'b1, acc, pop, got, rdy, qsz);
      n_chk++;
      if (rdy !== popped) begin n_fail++; $display("FAIL bp_s_ready_return: got %b required %b", rdy, popped); end
      if (pop) begin
        popped = 1'b1;
        e = exp_q.pop_front();
        seen++;
        n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL bp_order: got %h required %h", got, e); end
      end
    end
    n_chk++;
    if (seen != DEPTH) begin n_fail++; $display("FAIL bp_drain: got %0d required %0d", seen, DEPTH); exp_q.delete(); end
  endtask

  task automatic test_throughput();
    logic acc, pop, rdy;
    logic [32:0] got, e;
    logic [31:0] d;
    int qsz, n_acc, seen;
    n_acc = 0;
    seen = 0;
    for (int c = 0; c < 300 && (n_acc < 100 || exp_q.size() > 0); c++) begin
      d = rand_norm();
      cyc(n_acc < 100, d, ref_out(d), 1'b1, acc, pop, got, rdy, qsz);
      if (acc) n_acc++;
      n_chk++;
      if (rdy !== (qsz < DEPTH)) begin n_fail++; $display("FAIL tp_credit_ready: got %b required %b", rdy, qsz < DEPTH); end
      if (pop) begin
        e = exp_q.pop_front();
        seen++;
        n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL tp_data: got %h required %h (op %0d)", got, e, seen); end
      end
    end
    n_chk++;
    if (seen != 100) begin n_fail++; $display("FAIL tp_count: got %0d required 100", seen); exp_q.delete(); end
  endtask

  task automatic test_reset_mid();
    logic acc, pop, rdy;
    logic [32:0] got, e;
    int qsz, spurious, seen;
    spurious = 0;
    seen = 0;
    for (int c = 0; c < 5; c++) cyc(1'b1, 32'h41100000, 33'h040400000, 1'b1, acc, pop, got, rdy, qsz);
    for (int c = 5; c < 7; c++) cyc(1'b0, 32'd0, 33'd0, 1'b1, acc, pop, got, rdy, qsz);
    s_valid = 1'b0;
    rstn = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 25; c++) begin
      cyc(1'b0, 32'd0, 33'd0, 1'b1, acc, pop, got, rdy, qsz);
      if (pop || !rdy) spurious++;
    end
    n_chk++;
    if (spurious != 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d bad cycles required 0", spurious); end
    cyc(1'b1, 32'h40800000, 33'h040000000, 1'b1, acc, pop, got, rdy, qsz);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      cyc(1'b0, 32'd0, 33'd0, 1'b1, acc, pop, got, rdy, qsz);
      if (pop) begin
        e = exp_q.pop_front();
        seen++;
        n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL midrst_data: got %h required %h", got, e); end
      end
    end
    n_chk++;
    if (seen != 1) begin n_fail++; $display("FAIL midrst_count: got %0d required 1", seen); exp_q.delete(); end
  endtask

  task automatic test_random();
    logic [31:0] specials [9] = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h007FFFFF,
                                  32'h7F800000, 32'hFF800000, 32'hC0800000, 32'h7F800001,
                                  32'hFFA12345};
    logic acc, pop, rdy;
    logic [32:0] got, e;
    logic [31:0] d;
    int qsz, n_acc, seen;
    n_acc = 0;
    seen = 0;
    for (int c = 0; c < 1200 && (c < 400 || exp_q.size() > 0); c++) begin
      d = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 8)] : rand_norm();
      cyc((c < 400) && ($urandom_range(0, 2) != 0), d, ref_out(d),
          ($urandom_range(0, 1) == 1) || (c >= 400), acc, pop, got, rdy, qsz);
      if (acc) n_acc++;
      n_chk++;
      if (rdy !== (qsz < DEPTH)) begin n_fail++; $display("FAIL rnd_credit_ready: got %b required %b", rdy, qsz < DEPTH); end
      if (pop) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rnd_extra: got %h required no result", got);
        end else begin
          e = exp_q.pop_front();
          seen++;
          n_chk++;
          if (got !== e) begin n_fail++; $display("FAIL rnd_data: got %h required %h (op %0d)", got, e, seen); end
        end
      end
    end
    n_chk++;
    if (seen != n_acc) begin n_fail++; $display("FAIL rnd_count: got %0d results required %0d", seen, n_acc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_specials();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
